// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// access-size codes and per-size byte-lane masks.
package lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ0  = 3'd1,
      ST_WAIT0 = 3'd2,
      ST_REQ1  = 3'd3,
      ST_WAIT1 = 3'd4,
      ST_RESP  = 3'd5
   } lsu_state_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   // Size code 11 behaves exactly like a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == 2'b11) ? SZ_W : size;
   endfunction

   // Unshifted byte-lane mask for a (normalised) access size.
   function automatic logic [3:0] lane_mask(input logic [1:0] size);
      logic [3:0] m;
      case (size)
         SZ_B:    m = MASK_B;
         SZ_H:    m = MASK_H;
         default: m = MASK_W;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU (purely combinational).
// Store side: positions the lane mask and store data into an 8-lane /
// 64-bit window starting at the byte offset; lanes 3:0 belong to the first
// bus word, lanes 7:4 to the following word.
// Load side: shifts the two captured bus words down by the offset, trims
// to the access size and sign- or zero-extends.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        is_signed,
   input  logic [31:0] wdata,
   input  logic [31:0] buf0,
   input  logic [31:0] buf1,
   output logic [7:0]  be_win,
   output logic [63:0] wdata_win,
   output logic [31:0] load_result
);

   logic [5:0]  bit_off;
   logic [31:0] wdata_trim;
   logic [31:0] rd_win;

   assign bit_off = {1'b0, off, 3'b000};

   // Store window: trim data to the access size, then shift mask and data.
   always_comb begin
      wdata_trim = wdata;
      case (size)
         SZ_B:    wdata_trim = {24'h000000, wdata[7:0]};
         SZ_H:    wdata_trim = {16'h0000, wdata[15:0]};
         default: wdata_trim = wdata;
      endcase
      be_win    = {4'b0000, lane_mask(size)} << off;
      wdata_win = {32'h00000000, wdata_trim} << bit_off;
   end

   // Load extraction: only the low 32 bits of the shifted pair can matter.
   always_comb begin
      rd_win = 32'({buf1, buf0} >> bit_off);
      case (size)
         SZ_B:    load_result = {{24{is_signed & rd_win[7]}}, rd_win[7:0]};
         SZ_H:    load_result = {{16{is_signed & rd_win[15]}}, rd_win[15:0]};
         default: load_result = rd_win;
      endcase
   end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit in front of a word-organised data memory.
// Captures one command at a time, runs request/grant (and read-valid for
// loads) on the bus, and returns an extended load value with a one-cycle
// rsp_valid pulse. stall is high whenever the unit is not idle.
// Optional feature macro LSU_MISALIGN_SPLIT_EN: when defined, accesses that
// cross a word boundary are split into two bus accesses; when undefined,
// naturally misaligned halves/words fault without touching the bus.
module lsu_dmem_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              mem_rw,
   input  logic [1:0]        access_size,
   input  logic              is_signed,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rdata,
   output logic              misaligned,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [XLEN-1:0]   dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [XLEN-1:0]   dmem_rdata
);

   // Handshakes: the core command transfers on req_valid && req_ready
   // (req_ready is high only in IDLE). A bus access transfers on
   // dmem_req && dmem_gnt, with dmem_addr/be/we/wdata held stable until
   // then; each granted read returns exactly one dmem_rvalid, accepted only
   // while waiting for it. gnt/rvalid seen in any other state are ignored.

   lsu_state_t        state;

   logic              cmd_rw;
   logic              cmd_signed;
   logic              cmd_split;
   logic [1:0]        cmd_size;
   logic [1:0]        cmd_off;
   logic [ADDR_W-1:0] cmd_waddr;
   logic [3:0]        be_hi;
   logic [31:0]       wd_hi;
   logic [31:0]       buf0;
   logic [31:0]       buf1;

   logic [1:0]        in_size;
   logic              in_fault;
   logic              in_split;
   logic              al_idle;
   logic [1:0]        al_off;
   logic [1:0]        al_size;
   logic [31:0]       buf0_nx;
   logic [31:0]       buf1_nx;
   logic [7:0]        be_win;
   logic [63:0]       wdata_win;
   logic [31:0]       load_result;

   assign in_size = norm_size(access_size);

   // In IDLE the aligner looks at the incoming command so the first bus
   // access can be registered on the accept edge; afterwards it looks at
   // the captured command and the lane buffers.
   assign al_idle = (state == ST_IDLE);
   assign al_off  = al_idle ? addr[1:0] : cmd_off;
   assign al_size = al_idle ? in_size   : cmd_size;

   // Buffer values including a read word arriving this cycle, so the load
   // result can be registered on the same edge that ends the last wait.
   assign buf0_nx = (state == ST_WAIT0 && dmem_rvalid) ? dmem_rdata : buf0;
   assign buf1_nx = (state == ST_WAIT1 && dmem_rvalid) ? dmem_rdata : buf1;

`ifdef LSU_MISALIGN_SPLIT_EN
   assign in_fault = 1'b0;
   assign in_split = |be_win[7:4];
`else
   assign in_fault = ((in_size == SZ_H) && addr[0]) ||
                     ((in_size == SZ_W) && (addr[1:0] != 2'b00));
   assign in_split = 1'b0;
`endif

   lsu_align u_align (
      .off         (al_off),
      .size        (al_size),
      .is_signed   (cmd_signed),
      .wdata       (wdata),
      .buf0        (buf0_nx),
      .buf1        (buf1_nx),
      .be_win      (be_win),
      .wdata_win   (wdata_win),
      .load_result (load_result)
   );

   // Control FSM with registered bus and response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         req_ready  <= 1'b1;
         stall      <= 1'b0;
         rsp_valid  <= 1'b0;
         rdata      <= '0;
         misaligned <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
         cmd_rw     <= 1'b0;
         cmd_signed <= 1'b0;
         cmd_split  <= 1'b0;
         cmd_size   <= SZ_B;
         cmd_off    <= 2'b00;
         cmd_waddr  <= '0;
         be_hi      <= '0;
         wd_hi      <= '0;
         buf0       <= '0;
         buf1       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  cmd_rw     <= mem_rw;
                  cmd_signed <= is_signed;
                  cmd_size   <= in_size;
                  cmd_off    <= addr[1:0];
                  cmd_waddr  <= {addr[ADDR_W-1:2], 2'b00};
                  cmd_split  <= in_split;
                  be_hi      <= be_win[7:4];
                  wd_hi      <= mem_rw ? wdata_win[63:32] : 32'h0;
                  buf0       <= '0;
                  buf1       <= '0;
                  req_ready  <= 1'b0;
                  stall      <= 1'b1;
                  if (in_fault) begin
                     state      <= ST_RESP;
                     rsp_valid  <= 1'b1;
                     misaligned <= 1'b1;
                     rdata      <= '0;
                  end else begin
                     state      <= ST_REQ0;
                     dmem_req   <= 1'b1;
                     dmem_we    <= mem_rw;
                     dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                     dmem_be    <= be_win[3:0];
                     dmem_wdata <= mem_rw ? wdata_win[31:0] : 32'h0;
                  end
               end
            end

            ST_REQ0, ST_REQ1: begin
               if (dmem_gnt) begin
                  dmem_req <= 1'b0;
                  if (!cmd_rw) begin
                     state <= (state == ST_REQ0) ? ST_WAIT0 : ST_WAIT1;
                  end else if (state == ST_REQ0 && cmd_split) begin
                     state      <= ST_REQ1;
                     dmem_req   <= 1'b1;
                     dmem_addr  <= cmd_waddr + ADDR_W'(4);
                     dmem_be    <= be_hi;
                     dmem_wdata <= wd_hi;
                  end else begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rdata     <= '0;
                  end
               end
            end

            ST_WAIT0, ST_WAIT1: begin
               buf0 <= buf0_nx;
               buf1 <= buf1_nx;
               if (dmem_rvalid) begin
                  if (state == ST_WAIT0 && cmd_split) begin
                     state      <= ST_REQ1;
                     dmem_req   <= 1'b1;
                     dmem_addr  <= cmd_waddr + ADDR_W'(4);
                     dmem_be    <= be_hi;
                     dmem_wdata <= '0;
                  end else begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rdata     <= load_result;
                  end
               end
            end

            ST_RESP: begin
               state      <= ST_IDLE;
               rsp_valid  <= 1'b0;
               misaligned <= 1'b0;
               rdata      <= '0;
               req_ready  <= 1'b1;
               stall      <= 1'b0;
            end

            default: begin
               state     <= ST_IDLE;
               dmem_req  <= 1'b0;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               stall     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/lsu_dmem_ctrl.md
# lsu_dmem_ctrl

Load/store unit sitting directly downstream of the decode/control stage. It takes the memory command produced there (read/write select, access size, signedness) together with the ALU-computed address and rs2 store data. It runs a request/grant/response handshake to a word-organised data memory and returns a zero- or sign-extended load value to the writeback mux. While busy it stalls the core; misaligned accesses are handled by the compile-time policy below.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- XLEN, 32, data width; fixed at 32, four byte lanes

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  core presents a load/store this cycle
- req_ready  out  1  LSU idle and accepting
- mem_rw  in  1  0 = load, 1 = store
- access_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- is_signed  in  1  1 = sign-extend load result, 0 = zero-extend
- addr  in  ADDR_W  byte address
- wdata  in  XLEN  store data, LSB-justified
- rsp_valid  out  1  one-cycle completion pulse
- rdata  out  XLEN  extended load data, valid with rsp_valid, 0 for stores
- misaligned  out  1  fault flag, valid with rsp_valid
- stall  out  1  high whenever state is not IDLE
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write
- dmem_addr  out  ADDR_W  word-aligned bus address, bits [1:0] = 0
- dmem_be  out  4  byte-lane enables
- dmem_wdata  out  XLEN  lane-positioned write data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid; one per granted read
- dmem_rdata  in  XLEN  read data

## Operation
- Command is captured on req_valid && req_ready: addr, size, sign, rw, wdata into registers. Inputs are ignored otherwise.
- off = addr[1:0]. Lane mask: byte 0001, half 0011, word 1111. Mask and data are shifted left by off, 8*off bits, into an 8-lane / 64-bit window.
  - Lanes 3:0 form access 0 at {addr[31:2],2'b00}.
  - Lanes 7:4 form access 1 at that address + 4, wrapping modulo 2^ADDR_W.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - Accept moves to REQ0.
  - If the access is a fault (see Configuration), go straight to RESP with misaligned=1. No bus activity, no write.
- REQn:
  - dmem_req=1; address, be, wdata and we are held stable until dmem_gnt.
  - On gnt, a load goes to WAITn.
  - On gnt, a store goes to REQ1 if a second access is needed, else RESP.
- WAITn:
  - On dmem_rvalid, capture rdata into lane buffer n.
  - Then go to REQ1 if a second access is needed, else RESP.
- RESP:
  - rsp_valid=1 for one cycle, then return to IDLE.
  - Load result: {buf1,buf0} >> 8*off, truncated to size, then sign- or zero-extended.
- req_ready=1 only in IDLE. A new command is never accepted in the RESP cycle.

## Timing
- Reset values: req_ready=1, stall=0, rsp_valid=0, rdata=0, misaligned=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0; state IDLE.
- Accept in cycle 0 gives dmem_req in cycle 1.
- Store with same-cycle gnt: rsp_valid in cycle 2.
- Load with gnt in cycle 1 and rvalid in cycle 2: rsp_valid in cycle 3.
- Each gnt wait cycle and each rvalid wait cycle adds exactly 1 cycle.
- A split access adds REQ1 and WAIT1 with the same rules.
- Fault: rsp_valid in cycle 1.
- Reset mid-transaction: state returns to IDLE at the edge; dmem_req is low the next cycle. A late rvalid is ignored. No rsp_valid is produced for the aborted command.
- dmem_gnt or dmem_rvalid arriving outside REQn/WAITn is ignored.

## Configuration
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined:
  - Only accesses with off + bytes > 4 (half at off 3, word at off 1..3) use two bus accesses.
  - No access faults; misaligned stays 0.
  - A half at off 1 is a single access with be 0110.
- Undefined:
  - Natural alignment is required. Half with addr[0]=1, or word with off≠0, faults as described above.
  - REQ1 and WAIT1 are unreachable and may be removed.

## Structure
- Package lsu_pkg holds:
  - FSM state enum.
  - Size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10.
  - Lane-mask constants.
- Sub-module lsu_align (combinational) produces:
  - Store path: 8-lane byte-enable window and 64-bit shifted write data from off/size/wdata.
  - Load path: extracted, extended result from {buf1,buf0}/off/size/sign.
- lsu_dmem_ctrl holds the FSM, command registers and lane buffers.

## Test plan
- LW addr 0x100, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF -> rsp_valid in cycle 3, rdata 0xDEADBEEF, dmem_be 1111.
- LB addr 0x103, signed, rdata 0x80xxxxxx -> rdata 0xFFFFFF80; same access as LBU -> 0x00000080.
- SH addr 0x202, wdata 0x0000ABCD, gnt held low 2 cycles -> dmem_be 1100, dmem_wdata 0xABCD0000 stable throughout, rsp_valid 2 cycles later than no-wait case.
- SW addr 0x101:
  - Macro undefined -> misaligned=1 in cycle 1, dmem_req never asserted.
  - Macro defined -> be 1110 at 0x100, then 0001 at 0x104.
- LW addr 0x0FE with macro defined, words 0x11223344 then 0x55667788 -> rdata 0x77881122.
- Reset asserted in WAIT0, rvalid pulsed after -> no rsp_valid, req_ready=1 the cycle after reset.
